// File: rtl/i2c_codec_responder.sv
// I2C write-only target emulating the WM8731 codec register interface.
// Accepts 3-byte writes, ACKs valid bytes and keeps a 16-entry 9-bit register mirror.
`timescale 1ns/1ps

module i2c_codec_responder #(
    parameter logic [6:0] DEV_ADDR  = 7'h1A,
    parameter logic [6:0] RESET_REG = 7'h0F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_sclk,
    inout  wire        i2c_sdat,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       busy,
    output logic [7:0] write_count
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ACK_A,
        BYTE1,
        ACK_1,
        BYTE2,
        ACK_2,
        WAIT_STOP,
        IGNORE
    } state_t;

    state_t     state, state_n;
    logic [1:0] scl_sync, sda_sync;
    logic       scl_d, sda_d;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift_reg, shift_n;
    logic [7:0] byte1, byte1_n;
    logic       sda_drive, sda_drive_n;
    logic       busy_n;
    logic       commit;
    logic [8:0] mirror [16];

    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_cond, stop_cond;
    logic [6:0] cmd_addr;
    logic [8:0] cmd_data;
    logic       soft_rst;

    assign scl_s      = scl_sync[1];
    assign sda_s      = sda_sync[1];
    assign scl_rise   =  scl_s & ~scl_d;
    assign scl_fall   = ~scl_s &  scl_d;
    // SCL must be high on both samples so a data change during SCL low is never mistaken for START/STOP.
    assign start_cond =  scl_s &  scl_d &  sda_d & ~sda_s;
    assign stop_cond  =  scl_s &  scl_d & ~sda_d &  sda_s;

    // At ACK_2 the shift register still holds the second data byte.
    assign cmd_addr = byte1[7:1];
    assign cmd_data = {byte1[0], shift_reg};
    assign soft_rst = (cmd_addr == RESET_REG) && (cmd_data == 9'h000);

    assign i2c_sdat = sda_drive ? 1'b0 : 1'bz;
    assign rd_data  = mirror[rd_addr];

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (which would infer a latch).
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift_reg;
        byte1_n     = byte1;
        sda_drive_n = sda_drive;
        busy_n      = busy;
        commit      = 1'b0;

        if (start_cond) begin
            state_n     = ADDR;
            bit_cnt_n   = 3'd0;
            sda_drive_n = 1'b0;
            busy_n      = 1'b1;
        end else if (stop_cond) begin
            state_n     = IDLE;
            sda_drive_n = 1'b0;
        end else begin
            case (state)
                ADDR, BYTE1, BYTE2: begin
                    if (scl_rise) begin
                        shift_n   = {shift_reg[6:0], sda_s};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            case (state)
                                ADDR:    state_n = (shift_n == {DEV_ADDR, 1'b0}) ? ACK_A : IGNORE;
                                BYTE1: begin
                                    state_n = ACK_1;
                                    byte1_n = shift_n;
                                end
                                default: state_n = ACK_2;
                            endcase
                        end
                    end
                end
                ACK_A, ACK_1, ACK_2: begin
                    // First SCL fall (end of bit 8) pulls SDA low; the second ends the ACK clock.
                    if (scl_fall) begin
                        if (!sda_drive) begin
                            sda_drive_n = 1'b1;
                            commit      = (state == ACK_2);
                        end else begin
                            sda_drive_n = 1'b0;
                            case (state)
                                ACK_A:   state_n = BYTE1;
                                ACK_1:   state_n = BYTE2;
                                default: state_n = WAIT_STOP;
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end

        if (state_n == IDLE) begin
            busy_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // Synchronisers reset to the idle-bus level so release never fakes a START.
            scl_sync    <= 2'b11;
            sda_sync    <= 2'b11;
            scl_d       <= 1'b1;
            sda_d       <= 1'b1;
            state       <= IDLE;
            bit_cnt     <= 3'd0;
            shift_reg   <= 8'h00;
            byte1       <= 8'h00;
            sda_drive   <= 1'b0;
            busy        <= 1'b0;
            wr_valid    <= 1'b0;
            wr_addr     <= 7'h00;
            wr_data     <= 9'h000;
            write_count <= 8'h00;
            // NOTE: the mirror is explicitly cleared on reset because its contents are architecturally visible.
            for (int i = 0; i < 16; i++) begin
                mirror[i] <= 9'h000;
            end
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            scl_sync    <= {scl_sync[0], i2c_sclk};
            sda_sync    <= {sda_sync[0], i2c_sdat};
            scl_d       <= scl_s;
            sda_d       <= sda_s;
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            shift_reg   <= shift_n;
            byte1       <= byte1_n;
            sda_drive   <= sda_drive_n;
            busy        <= busy_n;
            wr_valid    <= commit;
            if (commit) begin
                wr_addr     <= cmd_addr;
                wr_data     <= cmd_data;
                write_count <= write_count + 8'd1;
                if (soft_rst) begin
                    for (int i = 0; i < 16; i++) begin
                        mirror[i] <= 9'h000;
                    end
                end else if (cmd_addr[6:4] == 3'b000) begin
                    mirror[cmd_addr[3:0]] <= cmd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Self-checking bench for i2c_codec_responder: bit-banged I2C initiator plus
// an abstract register-mirror model of the codec.
`timescale 1ns/1ps

module tb_i2c_codec_responder;

    localparam time Q = 60ns;  // quarter SCL period; SCL = clk/24

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       sda_low;
    wire        sda_bus;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic [3:0] rd_addr;
    logic [8:0] rd_data;
    logic       busy;
    logic [7:0] write_count;

    assign sda_bus = sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_codec_responder dut (
        .clk        (clk),
        .reset      (reset),
        .i2c_sclk   (scl),
        .i2c_sdat   (sda_bus),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .write_count(write_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int pulses = 0;

    always @(posedge clk) if (wr_valid) pulses <= pulses + 1;

    // Reference model: the codec's register file as seen by software.
    logic [8:0] m_mirror [16];
    logic [7:0] m_count;
    logic [6:0] m_addr;
    logic [8:0] m_data;

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_mirror[i] = 9'h000;
        m_count = 8'd0;
        m_addr  = 7'd0;
        m_data  = 9'd0;
    endtask

    task automatic m_write(input logic [7:0] b1, input logic [7:0] b2);
        int r;
        r       = int'(b1) / 2;
        m_addr  = b1[7:1];
        m_data  = {b1[0], b2};
        m_count = m_count + 8'd1;
        if (r == 15 && m_data == 9'h000) begin
            for (int i = 0; i < 16; i++) m_mirror[i] = 9'h000;
        end else if (r < 16) begin
            m_mirror[r] = m_data;
        end
    endtask

    // Bus initiator primitives; each begins and ends with SCL low (except stop).
    task automatic bus_start();
        #Q sda_low = 1'b0;
        #Q scl = 1'b1;
        #Q sda_low = 1'b1;
        #Q scl = 1'b0;
    endtask

    task automatic bus_stop();
        #Q sda_low = 1'b1;
        #Q scl = 1'b1;
        #Q sda_low = 1'b0;
        #Q;
    endtask

    task automatic send_bit(input logic b);
        #Q sda_low = ~b;
        #Q scl = 1'b1;
        #Q;
        #Q scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        #Q sda_low = 1'b0;
        #Q scl = 1'b1;
        #Q ack = (sda_bus === 1'b0);
        #Q scl = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            output logic [2:0] acks);
        logic a;
        bus_start();
        send_byte(b0, a); acks[2] = a;
        send_byte(b1, a); acks[1] = a;
        send_byte(b2, a); acks[0] = a;
        bus_stop();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        m_reset();
        @(negedge clk);
        n_vec++; if (wr_valid !== 1'b0) begin n_err++; $display("FAIL reset_wr_valid got %b want 0", wr_valid); end
        n_vec++; if (wr_addr !== 7'h00) begin n_err++; $display("FAIL reset_wr_addr got %h want 00", wr_addr); end
        n_vec++; if (wr_data !== 9'h000) begin n_err++; $display("FAIL reset_wr_data got %h want 000", wr_data); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (write_count !== 8'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", write_count); end
        n_vec++; if (sda_bus !== 1'b1) begin n_err++; $display("FAIL reset_sda got %b want 1 (released)", sda_bus); end
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i); #1;
            n_vec++; if (rd_data !== 9'h000) begin n_err++; $display("FAIL reset_mirror[%0d] got %h want 000", i, rd_data); end
        end
    endtask

    task automatic test_first_word();
        logic [2:0] acks;
        logic a;
        int p0;
        p0 = pulses;
        bus_start();
        #1;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL first_busy_set got %b want 1", busy); end
        send_byte(8'h34, a); acks[2] = a;
        send_byte(8'h0C, a); acks[1] = a;
        send_byte(8'h10, a); acks[0] = a;
        bus_stop();
        m_write(8'h0C, 8'h10);
        rd_addr = 4'd6; #1;
        n_vec++; if (acks !== 3'b111) begin n_err++; $display("FAIL first_acks got %b want 111", acks); end
        n_vec++; if (pulses - p0 != 1) begin n_err++; $display("FAIL first_pulses got %0d want 1", pulses - p0); end
        n_vec++; if (wr_addr !== 7'h06) begin n_err++; $display("FAIL first_wr_addr got %h want 06", wr_addr); end
        n_vec++; if (wr_data !== 9'h010) begin n_err++; $display("FAIL first_wr_data got %h want 010", wr_data); end
        n_vec++; if (rd_data !== 9'h010) begin n_err++; $display("FAIL first_mirror6 got %h want 010", rd_data); end
        n_vec++; if (write_count !== 8'd1) begin n_err++; $display("FAIL first_count got %0d want 1", write_count); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL first_busy_clear got %b want 0", busy); end
    endtask

    task automatic test_config_sequence();
        logic [15:0] words [11];
        logic [2:0]  acks;
        words = '{16'h0C10, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h08D5,
                  16'h0A04, 16'h0E01, 16'h1020, 16'h0C00, 16'h1201};
        for (int k = 0; k < 11; k++) begin
            do_write(8'h34, words[k][15:8], words[k][7:0], acks);
            m_write(words[k][15:8], words[k][7:0]);
            n_vec++; if (acks !== 3'b111) begin n_err++; $display("FAIL cfg_acks[%0d] got %b want 111", k, acks); end
        end
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i); #1;
            n_vec++; if (rd_data !== m_mirror[i]) begin n_err++; $display("FAIL cfg_mirror[%0d] got %h want %h", i, rd_data, m_mirror[i]); end
        end
        n_vec++; if (write_count !== m_count) begin n_err++; $display("FAIL cfg_count got %0d want %0d", write_count, m_count); end
    endtask

    task automatic test_bad_addr();
        logic [7:0] bad [2];
        logic [2:0] acks;
        int p0;
        bad = '{8'h36, 8'h35};
        for (int k = 0; k < 2; k++) begin
            p0 = pulses;
            do_write(bad[k], 8'h0C, 8'h99, acks);
            n_vec++; if (acks !== 3'b000) begin n_err++; $display("FAIL bad_acks[%h] got %b want 000", bad[k], acks); end
            n_vec++; if (pulses != p0) begin n_err++; $display("FAIL bad_pulses[%h] got %0d want 0", bad[k], pulses - p0); end
            n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bad_busy[%h] got %b want 0", bad[k], busy); end
        end
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i); #1;
            n_vec++; if (rd_data !== m_mirror[i]) begin n_err++; $display("FAIL bad_mirror[%0d] got %h want %h", i, rd_data, m_mirror[i]); end
        end
        n_vec++; if (write_count !== m_count) begin n_err++; $display("FAIL bad_count got %0d want %0d", write_count, m_count); end
    endtask

    task automatic test_abort();
        logic [2:0] acks;
        logic a;
        int p0;
        do_write(8'h34, 8'h08, 8'h33, acks);
        m_write(8'h08, 8'h33);
        p0 = pulses;
        bus_start();
        send_byte(8'h34, a);
        send_byte(8'h08, a);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom));
        bus_stop();
        rd_addr = 4'd4; #1;
        n_vec++; if (pulses != p0) begin n_err++; $display("FAIL abort_stop_pulses got %0d want 0", pulses - p0); end
        n_vec++; if (rd_data !== m_mirror[4]) begin n_err++; $display("FAIL abort_stop_mirror4 got %h want %h", rd_data, m_mirror[4]); end
        n_vec++; if (write_count !== m_count) begin n_err++; $display("FAIL abort_stop_count got %0d want %0d", write_count, m_count); end
        p0 = pulses;
        bus_start();
        send_byte(8'h34, a);
        send_byte(8'h08, a);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom));
        bus_start();
        send_byte(8'h34, a); acks[2] = a;
        send_byte(8'h08, a); acks[1] = a;
        send_byte(8'hD5, a); acks[0] = a;
        bus_stop();
        m_write(8'h08, 8'hD5);
        rd_addr = 4'd4; #1;
        n_vec++; if (acks !== 3'b111) begin n_err++; $display("FAIL abort_rs_acks got %b want 111", acks); end
        n_vec++; if (pulses - p0 != 1) begin n_err++; $display("FAIL abort_rs_pulses got %0d want 1", pulses - p0); end
        n_vec++; if (rd_data !== m_mirror[4]) begin n_err++; $display("FAIL abort_rs_mirror4 got %h want %h", rd_data, m_mirror[4]); end
    endtask

    task automatic test_soft_reset();
        logic [3:0] acks;
        logic a;
        int p0;
        p0 = pulses;
        bus_start();
        send_byte(8'h34, a); acks[3] = a;
        send_byte(8'h1E, a); acks[2] = a;
        send_byte(8'h00, a); acks[1] = a;
        send_byte(8'($urandom), a); acks[0] = a;
        bus_stop();
        m_write(8'h1E, 8'h00);
        n_vec++; if (acks !== 4'b1110) begin n_err++; $display("FAIL srst_acks got %b want 1110", acks); end
        n_vec++; if (pulses - p0 != 1) begin n_err++; $display("FAIL srst_pulses got %0d want 1", pulses - p0); end
        n_vec++; if (wr_addr !== m_addr) begin n_err++; $display("FAIL srst_wr_addr got %h want %h", wr_addr, m_addr); end
        n_vec++; if (write_count !== m_count) begin n_err++; $display("FAIL srst_count got %0d want %0d", write_count, m_count); end
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i); #1;
            n_vec++; if (rd_data !== m_mirror[i]) begin n_err++; $display("FAIL srst_mirror[%0d] got %h want %h", i, rd_data, m_mirror[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] acks;
        logic a;
        bus_start();
        send_byte(8'h34, a);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom));
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        n_vec++; if (sda_bus !== 1'b1) begin n_err++; $display("FAIL rmid_sda got %b want 1", sda_bus); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %b want 0", busy); end
        n_vec++; if (write_count !== 8'd0) begin n_err++; $display("FAIL rmid_count got %0d want 0", write_count); end
        reset = 1'b0;
        m_reset();
        bus_stop();
        do_write(8'h34, 8'h0C, 8'h10, acks);
        m_write(8'h0C, 8'h10);
        rd_addr = 4'd6; #1;
        n_vec++; if (acks !== 3'b111) begin n_err++; $display("FAIL rmid_acks got %b want 111", acks); end
        n_vec++; if (rd_data !== m_mirror[6]) begin n_err++; $display("FAIL rmid_mirror6 got %h want %h", rd_data, m_mirror[6]); end
        n_vec++; if (write_count !== m_count) begin n_err++; $display("FAIL rmid_count2 got %0d want %0d", write_count, m_count); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b0, b1, b2;
        logic [2:0] acks, exp_acks;
        logic a;
        logic good;
        int p0, n_good;
        for (int it = 0; it < 8; it++) begin
            p0 = pulses;
            n_good = 0;
            bus_start();
            for (int k = 0; k < 3; k++) begin
                if (k > 0) bus_start();
                good = ($urandom_range(0, 4) != 0);
                b0 = good ? 8'h34 : 8'($urandom_range(0, 255));
                if (!good && b0 == 8'h34) b0 = 8'h35;
                b1 = 8'($urandom_range(0, 255));
                b2 = 8'($urandom_range(0, 255));
                send_byte(b0, a); acks[2] = a;
                send_byte(b1, a); acks[1] = a;
                send_byte(b2, a); acks[0] = a;
                exp_acks = good ? 3'b111 : 3'b000;
                if (good) begin
                    m_write(b1, b2);
                    n_good++;
                end
                n_vec++; if (acks !== exp_acks) begin n_err++; $display("FAIL b2b_acks[%0d.%0d] got %b want %b", it, k, acks, exp_acks); end
            end
            bus_stop();
            n_vec++; if (pulses - p0 != n_good) begin n_err++; $display("FAIL b2b_pulses[%0d] got %0d want %0d", it, pulses - p0, n_good); end
            n_vec++; if (write_count !== m_count) begin n_err++; $display("FAIL b2b_count[%0d] got %0d want %0d", it, write_count, m_count); end
            for (int i = 0; i < 16; i++) begin
                rd_addr = 4'(i); #1;
                n_vec++; if (rd_data !== m_mirror[i]) begin n_err++; $display("FAIL b2b_mirror[%0d][%0d] got %h want %h", it, i, rd_data, m_mirror[i]); end
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        scl     = 1'b1;
        sda_low = 1'b0;
        rd_addr = 4'd0;
        test_reset();
        test_first_word();
        test_config_sequence();
        test_bad_addr();
        test_abort();
        test_soft_reset();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_codec_responder.md
Name: i2c_codec_responder

Overview:
Synthesizable I2C target that emulates the write-only register interface of the WM8731 audio codec at the far end of the codec configuration bus. It receives 3-byte write transactions (device address, then {reg[6:0], data[8]}, then data[7:0]), ACKs valid bytes and stores the 9-bit values in a 16-entry register mirror. It is used for on-chip loopback of the codec config sequencer and as a register-level codec model in system sims.

Parameters:
DEV_ADDR  7'h1A  7-bit target address; the write address byte is 8'h34.
RESET_REG  7'h0F  Register address that triggers a soft reset of the mirror when written with data 9'h000.

Ports:
clk  input  1  system clock; must be at least 8x the SCL rate.
reset  input  1  synchronous, active-high.
i2c_sclk  input  1  bus clock from the initiator. Asynchronous to clk.
i2c_sdat  inout  1  open-drain data line. The block drives only 1'b0 or 1'bz.
wr_valid  output  1  one-cycle pulse when a complete write is accepted.
wr_addr  output  7  register address of the last accepted write.
wr_data  output  9  data of the last accepted write.
rd_addr  input  4  mirror read index.
rd_data  output  9  combinational read of mirror[rd_addr].
busy  output  1  high from START until STOP or return to IDLE.
write_count  output  8  accepted writes since reset. Wraps 255->0.

Behaviour:
- Reset values:
  - wr_valid = 0, wr_addr = 0, wr_data = 0, busy = 0, write_count = 0.
  - All 16 mirror entries = 9'h000.
  - SDA released (z). State = IDLE.
- Input synchronisation:
  - SCL and SDA each pass through a 2-flop synchroniser, followed by one history flop for edge detection.
  - All events below refer to the synchronised signals, so they are 2-3 clk cycles late relative to the pins.
- Bus conditions:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Data bits are sampled MSB-first on SCL rising edges.
- ACK timing:
  - Drive SDA low on the SCL falling edge that follows the 8th bit.
  - Release SDA on the next SCL falling edge, which ends the 9th clock.
  - NACK means SDA is left released.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. On the 8th bit, if the byte equals {DEV_ADDR, 1'b0}, go to ACK_A; otherwise (address mismatch or R/W=1) go to IGNORE with NACK.
  - ACK_A -> BYTE1: shift 8 bits, latch reg[6:0] and data[8]. Then ACK_1.
  - ACK_1 -> BYTE2: shift 8 bits, latch data[7:0]. Then ACK_2.
  - ACK_2: drive ACK. On the cycle the ACK is asserted, pulse wr_valid, update wr_addr/wr_data and increment write_count. Update the mirror only if reg[6:4] == 0. Then go to WAIT_STOP.
  - WAIT_STOP: any further data byte is NACKed and ignored.
  - IGNORE: do not drive SDA; wait for STOP or START.
- Soft reset: a write to RESET_REG with data 9'h000 clears all mirror entries in the same cycle as wr_valid. RESET_REG is itself stored as 0. wr_valid still pulses and write_count still increments.
- Bus-condition priority:
  - STOP in any state -> IDLE and SDA released. An incomplete transaction causes no write and no wr_valid.
  - START (including repeated START) in any state -> ADDR with the bit counter cleared. This aborts a partial transaction with no write.
  - START/STOP detection takes priority over bit sampling in the same cycle.
- busy:
  - Set on START.
  - Cleared on STOP, or on entering IDLE.
- Reset mid-transaction: state returns to IDLE and SDA is released within one cycle. Mirror and counters clear. The block resynchronises on the next START.
- SDA must never be driven while SCL is high, except to hold an ACK level that was set during SCL low.

Test Plan:
- Write 34/0C/10 (the config sequencer's first word, 16'h0C10) -> three ACKs, wr_valid once, wr_addr = 7'h06, wr_data = 9'h010, mirror[6] = 9'h010, write_count = 1.
- Full config sequence 0C10, 0017, 0217, 0479, 0679, 08D5, 0A04, 0E01, 1020, 0C00, 1201 -> mirror[0] = 017, [1] = 017, [2] = 079, [3] = 079, [4] = 0D5, [5] = 004, [6] = 000, [7] = 001, [8] = 020, [9] = 001; write_count = 11.
- Address byte 36 or 35 -> NACK on the 9th clock, no ACKs for the following bytes, no wr_valid, mirror unchanged, busy drops on STOP.
- START, 34, 08, then STOP after 4 bits of byte 2 -> no wr_valid, mirror[4] unchanged. Repeated START mid-byte followed by a valid 34/08/D5 -> mirror[4] = 0D5.
- Write 34/1E/00 after the config sequence -> all mirror entries = 000, wr_addr = 0F, write_count increments. A 4th data byte after byte 2 is NACKed with no extra write.
- reset asserted during BYTE1 -> SDA released next cycle, busy = 0, write_count = 0. A subsequent valid write completes normally.
